// File: rtl/wheels_pwm.sv
// Two-channel H-bridge PWM drive with reversal dead time.
// Optional duty ramping: define WHEELS_RAMP_EN.
module wheels_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 100,
  parameter int DEAD_CYCLES = 5000,
  parameter int RAMP_STEP   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          state,
  input  logic [PWM_BITS-1:0] speed,
  output logic [1:0]          right,
  output logic [1:0]          left,
  output logic                busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DEAD_LD  = DW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_DEAD
  } wst_t;

  typedef enum logic [1:0] {
    D_STOP,
    D_FWD,
    D_REV
  } dir_t;

  // A non-positive step would freeze the ramp.
  if (RAMP_STEP < 1) begin : g_ramp_step_invalid
  end

  logic [2:0]          state_q;
  logic [PWM_BITS-1:0] speed_q;
  logic [PW-1:0]       pre_q;
  logic [PW-1:0]       pre_d;
  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_d;
  logic                tick;
  logic                wrap;
  logic                busy_q;
  logic                busy_d;
  dir_t                cmd [2];
  logic [1:0]          drv [2];
  logic [1:0]          in_dead;

  // Capture command and speed every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 3'b011;
      speed_q <= '0;
    end else begin
      state_q <= state;
      speed_q <= speed;
    end
  end

  assign tick = (pre_q == PRE_LAST);
  assign wrap = tick && (cnt_q == '1);

  // Shared prescaler and PWM counter next state.
  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
  end

  // Shared prescaler and PWM counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  // Motion command to per-wheel direction; [0] right, [1] left.
  always_comb begin
    cmd[0] = D_STOP;
    cmd[1] = D_STOP;
    unique case (state_q)
      3'b000: begin
        cmd[0] = D_FWD;
        cmd[1] = D_FWD;
      end
      3'b001: cmd[1] = D_FWD;
      3'b010: cmd[0] = D_FWD;
      3'b100: begin
        cmd[0] = D_REV;
        cmd[1] = D_FWD;
      end
      3'b101: begin
        cmd[0] = D_REV;
        cmd[1] = D_REV;
      end
      default: begin
        cmd[0] = D_STOP;
        cmd[1] = D_STOP;
      end
    endcase
  end

  for (genvar w = 0; w < 2; w++) begin : g_wheel
    wst_t                st_q;
    wst_t                st_d;
    dir_t                dir_q;
    dir_t                dir_d;
    logic [DW-1:0]       dead_q;
    logic [DW-1:0]       dead_d;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic [PWM_BITS-1:0] duty_nx;
    logic                on;

`ifdef WHEELS_RAMP_EN
    localparam int STEP_SAT =
      (RAMP_STEP > (1 << PWM_BITS)) ? (1 << PWM_BITS) :
      (RAMP_STEP < 1) ? 1 : RAMP_STEP;
    localparam logic [PWM_BITS:0] STEP = (PWM_BITS+1)'(STEP_SAT);
    logic [PWM_BITS:0] cur;
    logic [PWM_BITS:0] tgt;
    logic [PWM_BITS:0] up;
    logic [PWM_BITS:0] dn;

    // Move duty one step toward speed, clamping at speed.
    always_comb begin
      cur = {1'b0, duty_q};
      tgt = {1'b0, speed_q};
      up  = cur + STEP;
      dn  = (cur >= STEP) ? cur - STEP : '0;
      duty_nx = speed_q;
      if (cur < tgt) begin
        duty_nx = (up > tgt) ? speed_q : up[PWM_BITS-1:0];
      end else begin
        duty_nx = (dn < tgt) ? speed_q : dn[PWM_BITS-1:0];
      end
    end
`else
    assign duty_nx = speed_q;
`endif

    assign on = (duty_q == '1) || (cnt_q < duty_q);
    assign drv[w] = (st_q == ST_RUN && on) ?
                    ((dir_q == D_REV) ? 2'b10 : 2'b01) : 2'b00;
    assign in_dead[w] = (st_d == ST_DEAD);

    // Wheel FSM: STOP / RUN / DEAD with duty and dead counter.
    always_comb begin
      st_d   = st_q;
      dir_d  = dir_q;
      dead_d = dead_q;
      duty_d = duty_q;
      unique case (st_q)
        ST_STOP: begin
          duty_d = '0;
          dead_d = '0;
          if (cmd[w] != D_STOP) begin
            st_d  = ST_RUN;
            dir_d = cmd[w];
          end
        end
        ST_RUN: begin
          if (cmd[w] == D_STOP) begin
            st_d   = ST_STOP;
            duty_d = '0;
          end else if (cmd[w] != dir_q) begin
            st_d   = ST_DEAD;
            dir_d  = cmd[w];
            dead_d = DEAD_LD;
            duty_d = '0;
          end else if (wrap) begin
            duty_d = duty_nx;
          end
        end
        ST_DEAD: begin
          if (cmd[w] == D_STOP) begin
            st_d   = ST_STOP;
            dead_d = '0;
          end else if (cmd[w] != dir_q) begin
            dir_d  = cmd[w];
            dead_d = DEAD_LD;
          end else if (dead_q == '0) begin
            st_d = ST_RUN;
          end else begin
            dead_d = dead_q - 1'b1;
          end
        end
        default: begin
          st_d   = ST_STOP;
          dir_d  = D_STOP;
          dead_d = '0;
          duty_d = '0;
        end
      endcase
    end

    // Wheel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= ST_STOP;
        dir_q  <= D_STOP;
        dead_q <= '0;
        duty_q <= '0;
      end else begin
        st_q   <= st_d;
        dir_q  <= dir_d;
        dead_q <= dead_d;
        duty_q <= duty_d;
      end
    end
  end

  assign busy_d = |in_dead;

  // busy tracks the DEAD state of either wheel, cycle-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= busy_d;
  end

  assign right = drv[0];
  assign left  = drv[1];
  assign busy  = busy_q;

endmodule

// File: doc/wheels_pwm.md
# wheels_pwm

Two-channel H-bridge drive controller with PWM speed control, direction-reversal dead time and optional duty ramping. It replaces the bare direction decoder between the navigation FSM and the right/left motor driver pins. It decodes the same 3-bit motion command, adds a speed input, and guarantees that each bridge never sees both direction inputs high. Each bridge also coasts for a programmable dead time before it reverses.

## Interface
- PWM_BITS, 8: duty/counter width; PWM period = 2^PWM_BITS ticks
- PRESCALE, 100: clk cycles per PWM tick (≥1)
- DEAD_CYCLES, 5000: clk cycles of coast (00) inserted on a direction reversal (≥1)
- RAMP_STEP, 8: duty increment per PWM period when ramping (≥1)
- clk  in  1  system clock; everything in this block is clocked by clk
- rst_n  in  1  asynchronous, active-low reset
- state  in  3  motion command: 000 forward, 001 right turn, 010 left turn, 011 stop, 100 spin, 101 reverse, 110/111 stop
- speed  in  PWM_BITS  target duty; 0 = off, all-ones = 100 %
- right  out  2  right bridge: [0] forward, [1] reverse
- left  out  2  left bridge: [0] forward, [1] reverse
- busy  out  1  high while either wheel is in DEAD

## Operation
- Inputs are registered every cycle, with no handshake. The command decodes to a per-wheel direction from {STOP, FWD, REV}:
  - 000: R=FWD, L=FWD
  - 001: R=STOP, L=FWD
  - 010: R=FWD, L=STOP
  - 011/110/111: both STOP
  - 100: R=REV, L=FWD
  - 101: both REV
- Each wheel has its own FSM with states STOP, RUN, DEAD:
  - STOP→RUN when the decoded direction is FWD or REV. No dead time is inserted.
  - RUN→STOP when the decoded direction is STOP. Outputs go to 00 and duty is cleared to 0.
  - RUN→DEAD when the decoded direction is opposite to the running direction. The dead counter loads DEAD_CYCLES−1, the target direction is latched, and duty is cleared to 0.
  - In DEAD, if the decoded direction is STOP, go to STOP.
  - In DEAD, if the decoded direction equals the latched target, keep counting.
  - In DEAD, if the decoded direction is opposite to the latched target, reload the counter and latch the new target.
  - DEAD→RUN in the target direction when the counter reaches 0.
- PWM:
  - A shared prescaler produces a 1-cycle tick every PRESCALE clks.
  - A shared PWM counter increments on each tick and wraps from 2^PWM_BITS−1 to 0.
  - Per-wheel "on" = (duty == all-ones) or (cnt < duty).
- Outputs:
  - In RUN with "on" true, drive 10 for REV and 01 for FWD.
  - In every other case drive 00.
  - 11 is never driven, in any state.
- Duty update happens only at the period wrap (tick with cnt == all-ones), so no mid-period glitches occur.

## Timing
- Reset: right=00, left=00, busy=0, all FSMs in STOP, prescaler/counter/duty/dead counters at 0. Reset takes effect asynchronously; release is synchronous to clk.
- Reset asserted mid-DEAD or mid-RUN forces outputs to 00 immediately.
- Command latency: a state change at edge N is registered at N+1. FSM and outputs update at N+2.
- Entering STOP forces 00 two cycles after the command, independent of PWM phase.
- Dead time: from the RUN→DEAD edge, outputs hold 00 for exactly DEAD_CYCLES clks, then the wheel enters RUN.
- The first "on" output after DEAD follows the duty rules below.
- busy is registered and asserts in the same cycle as the FSM's DEAD state.
- speed changes take effect at the next period wrap.
- The speed value is saturated by its width; no overflow is possible.

## Configuration
- WHEELS_RAMP_EN defined:
  - At each period wrap, in RUN, duty moves toward speed by RAMP_STEP and clamps at speed. The arithmetic is PWM_BITS+1 wide so no wrap-around can occur.
  - Decreases in speed also ramp down by RAMP_STEP per period.
  - Duty restarts from 0 after STOP or DEAD.
- WHEELS_RAMP_EN undefined: duty loads speed directly at the next period wrap in RUN, and RAMP_STEP is unused.

## Test plan
All scenarios use PWM_BITS=4, PRESCALE=1, DEAD_CYCLES=8, RAMP_STEP=4.
- Reset scenario: assert rst_n=0 mid-run → right=left=00 and busy=0 immediately. After release with state=011, outputs stay 00.
- Forward PWM scenario (no ramp): state=000, speed=4 → after the first wrap, right=left=01 for 4 of every 16 clks, else 00. With speed=15, outputs are constant 01.
- Reversal scenario: state=000 running, then state=101 → both wheels drive 00 and busy=1 for exactly 8 clks, then drive 10 with PWM. 11 is never observed.
- Re-reversal inside DEAD: in DEAD toward REV, command 000 at dead-count 3 → counter reloads and 00 holds 8 more clks before 01. With state=011 during DEAD instead, busy drops two cycles later and the wheel stays STOP.
- Ramp scenario (WHEELS_RAMP_EN): state=000, speed=12 from STOP → duty is 4, 8, 12 over successive periods and then holds. Changing speed to 0 gives duty 8, 4, 0.
- Turn and illegal-code scenario: state=100 → right=10, left=01 with no dead time from STOP. state=111 → both 00 within 2 cycles.
